gsim_job_sched: RTL
===================

GSIM_JOB_SCHED -- requirements
Module: gsim_job_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2047: maximum cycles in WAIT before core_out_valid is seen.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req0_valid, input, 1: client 0 offers a b word.
REQ-005 SHALL have port req0_data, input, 16: client 0 b word, signed.
REQ-006 SHALL have port req0_ready, output, 1: client 0 word accepted this cycle when req0_valid is also high.
REQ-007 SHALL have ports req1_valid, req1_data and req1_ready with the same widths and meaning for client 1.
REQ-008 SHALL have port core_in_en, output, 1: drives the solver core input-enable.
REQ-009 SHALL have port core_b_in, output, 16: drives the solver core b input.
REQ-010 SHALL have port core_out_valid, input, 1: solver core result strobe.
REQ-011 SHALL have port core_x_out, input, 32: solver core result word.
REQ-012 SHALL have port resp_valid, output, 1: result word available.
REQ-013 SHALL have port resp_ready, input, 1: requester accepts the result word.
REQ-014 SHALL have port resp_data, output, 32: result word.
REQ-015 SHALL have port resp_id, output, 1: client owning the current job.
REQ-016 SHALL have port resp_last, output, 1: high on the 16th result word.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-018 SHALL have port timeout_err, output, 1: one-cycle pulse on timeout.

Function
REQ-019 SHALL implement four states: IDLE, LOAD, WAIT, RETURN.
REQ-020 IDLE: if any reqN_valid is high, SHALL latch grant and enter LOAD on the next cycle; if both are high, the client not granted last SHALL win.
REQ-021 SHALL update last_grant at grant time only.
REQ-022 LOAD: ready of the granted client = 1 and ready of the other client = 0; core_in_en = granted valid; core_b_in = granted data, combinational pass-through.
REQ-023 LOAD: a 4-bit word counter SHALL increment on each valid&ready; the 16th handshake SHALL move to WAIT; valid gaps SHALL be tolerated.
REQ-024 Outside LOAD, core_in_en SHALL be 0, core_b_in 0, and both reqN_ready 0.
REQ-025 WAIT: each cycle with core_out_valid=1 SHALL write core_x_out into buf[cnt] (16x32 buffer, cnt from 0); the 16th write SHALL move to RETURN with the read pointer at 0.
REQ-026 WAIT: a cycle counter SHALL clear on WAIT entry and count while no result word has arrived; reaching TIMEOUT SHALL pulse timeout_err and return to IDLE with no response issued.
REQ-027 The timeout counter SHALL stop once the first core_out_valid is seen.
REQ-028 RETURN: resp_valid = 1, resp_data = buf[rptr], resp_id = grant, resp_last = (rptr==15); rptr SHALL advance on resp_valid&resp_ready.
REQ-029 The last handshake SHALL move to IDLE; a new grant is allowed in the following cycle.
REQ-030 resp_valid SHALL hold with stable resp_data until accepted; resp_ready may stall indefinitely.
REQ-031 core_out_valid outside WAIT SHALL be ignored, with no buffer write.
REQ-032 Counters SHALL be 4-bit and SHALL reset to 0 on every state entry that uses them.
REQ-033 resp_valid, core_in_en and both reqN_ready SHALL be 0 in IDLE.

Reset
REQ-034 Asserting reset SHALL, at any time including mid-job, force IDLE and clear the counters.
REQ-035 Asserting reset SHALL set last_grant=1, so client 0 wins the first tie.
REQ-036 Asserting reset SHALL drive all outputs to 0; buffer contents are don't-care.
REQ-037 After reset release, the first grant SHALL occur on the first clock edge at which some reqN_valid is high.

Verification
REQ-038 Scenario: client 0 alone streams b=1..16 with no gaps; core model returns x=0x100..0x10F -> 16 core_in_en pulses carry 1..16, then resp words 0x100..0x10F with resp_id=0 and resp_last on 0x10F.
REQ-039 Scenario: both clients are valid from reset, three jobs back-to-back -> grant order 0,1,0, and the idle client's ready stays 0 throughout the other's LOAD.
REQ-040 Scenario: client 1 inserts 3-cycle valid gaps after words 4 and 9 -> exactly 16 core_in_en pulses, in order, with no duplicates.
REQ-041 Scenario: resp_ready is low for 5 cycles at rptr=7 -> resp_data holds buf[7] stable and no word is lost or repeated.
REQ-042 Scenario: the core never asserts out_valid, TIMEOUT=20 -> timeout_err pulses exactly 20 cycles after WAIT entry, then the block is IDLE with busy=0.
REQ-043 Scenario: reset is asserted at LOAD word 9 -> all outputs go 0 immediately; the next job restarts at word 0, client 0 wins a tie, and the stale out_valid is ignored.

Source files
------------

// File: rtl/gsim_job_sched.sv
// Job scheduler between two b-vector clients and a solver core: arbitrates a client, streams its
// 16 b words into the core, buffers the 16 result words and hands them back to that client.
module gsim_job_sched #(
  parameter int TIMEOUT = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        core_in_en,
  output logic [15:0] core_b_in,
  input  logic        core_out_valid,
  input  logic [31:0] core_x_out,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_last,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RETURN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant;
  logic          r_last_grant;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_seen;
  logic          r_timeout_err;
  logic [31:0]   r_buf [16];

  logic          w_any_req;
  logic          w_pick;
  logic          w_gnt_valid;
  logic [15:0]   w_gnt_data;
  logic          w_load_hs;
  logic          w_core_wr;
  logic          w_resp_hs;
  logic          w_timeout;

  // On a tie the client that was not granted last time wins.
  assign w_any_req   = req0_valid | req1_valid;
  assign w_pick      = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_gnt_valid = r_grant ? req1_valid : req0_valid;
  assign w_gnt_data  = r_grant ? req1_data : req0_data;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_in_en = 1'b0;
    core_b_in  = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_id    = 1'b0;
    resp_last  = 1'b0;
    w_load_hs  = 1'b0;
    w_core_wr  = 1'b0;
    w_resp_hs  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_LOAD;
      end
      S_LOAD: begin
        req0_ready = ~r_grant;
        req1_ready = r_grant;
        core_in_en = w_gnt_valid;
        core_b_in  = w_gnt_data;
        w_load_hs  = w_gnt_valid;
        if (w_load_hs && r_cnt == 4'd15) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_core_wr = core_out_valid;
        // The watchdog only guards the silence before the first result word.
        if (w_core_wr && r_cnt == 4'd15) begin
          w_next = S_RETURN;
        end else if (!core_out_valid && !r_seen && r_timer == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RETURN: begin
        resp_valid = 1'b1;
        resp_data  = r_buf[r_cnt];
        resp_id    = r_grant;
        resp_last  = (r_cnt == 4'd15);
        w_resp_hs  = resp_ready;
        if (w_resp_hs && r_cnt == 4'd15) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One shared word counter: LOAD word index, WAIT write index, RETURN read pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_seen        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state == S_IDLE && w_any_req) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      if (w_next != r_state)                     r_cnt <= '0;
      else if (w_load_hs || w_core_wr || w_resp_hs) r_cnt <= r_cnt + 4'd1;
      if (r_state != S_WAIT) begin
        r_timer <= '0;
        r_seen  <= 1'b0;
      end else if (w_core_wr) begin
        r_seen <= 1'b1;
      end else if (!r_seen) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_core_wr) r_buf[r_cnt] <= core_x_out;
  end

endmodule
